multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM for the multi-cycle variant of the SDC24 QP core. It sequences a shared-memory datapath (one memory, one ALU, IR/A/B/ALUOut/MDR holding registers) through fetch, decode, execute, memory and write-back steps, one instruction at a time. It supports the same ISA subset as the single-cycle core and stalls on a memory-ready handshake.

## Interface
- `STATE_W`, default 4: width of the debug state output.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `opCode` input 6: IR[31:26]; valid from DECODE onward.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU zero flag from the current cycle.
- `mem_ready` input 1: memory has completed the access requested this cycle.
- `PCWrite` output 1: PC load enable, already gated with `zero` for branches.
- `IorD` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemReadEn` output 1: memory read request.
- `MemWriteEn` output 1: memory write request.
- `IRWrite` output 1: IR load enable.
- `RegDst` output 2: destination register select; 00 = rt, 01 = rd, 10 = $31.
- `MemtoReg` output 2: write-back data select; 00 = ALUOut, 01 = MDR, 10 = PC.
- `RegWriteEn` output 1: register file write enable.
- `ALUSrcA` output 2: ALU A select; 00 = PC, 01 = A, 10 = shamt.
- `ALUSrcB` output 2: ALU B select; 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- `ALUOp` output 4: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 sgt, 0110 nor, 0111 xor, 1000 sll, 1001 srl.
- `PCSource` output 2: PC next-value select; 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A.
- `instr_done` output 1: one-cycle pulse on the last cycle of each instruction.
- `illegal` output 1: one-cycle pulse when the opcode or R-type funct is unsupported.
- `state` output STATE_W: current FSM state, for debug.

## Operation
- Opcodes: R=00, addi=08, lw=23, sw=2B, beq=04, bne=05, jal=03, ori=0D, xori=16.
- R-type functs: add 20, sub 22, and 24, or 25, slt 2A, sgt 14, sll 00, srl 02, nor 27, xor 15, jr 08.
- Outputs are decoded from the current state (Moore). The only exceptions are the `mem_ready` and `zero` gating described below.
- Every output not listed for a state is 0.

States and actions:
- FETCH (0): IorD=0, MemReadEn=1, ALUSrcA=00, ALUSrcB=01, ALUOp=add.
  - If `mem_ready`: IRWrite=1, PCWrite=1, PCSource=00, next state DECODE.
  - Otherwise stay in FETCH with IRWrite=0 and PCWrite=0.
- DECODE (1): ALUSrcA=00, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADDR.
  - R-type with a supported funct other than jr → EXEC_R.
  - R-type with funct jr → JR.
  - addi/ori/xori → EXEC_I.
  - beq/bne → BRANCH.
  - jal → JAL.
  - Any other opcode, or an unsupported funct → FETCH with `illegal`=1 and `instr_done`=1.
- MEMADDR (2): ALUSrcA=01, ALUSrcB=10, add. Next: MEMRD for lw, MEMWR for sw.
- MEMRD (3): IorD=1, MemReadEn=1. Stay until `mem_ready`, then WB_MEM.
- WB_MEM (4): RegDst=00, MemtoReg=01, RegWriteEn=1, `instr_done`. Next FETCH.
- MEMWR (5): IorD=1, MemWriteEn=1. Stay until `mem_ready`; on that cycle assert `instr_done`, then go to FETCH.
- EXEC_R (6): ALUSrcB=00, ALUOp from funct. ALUSrcA=10 for sll/srl, otherwise 01. Next WB_R.
- WB_R (7): RegDst=01, MemtoReg=00, RegWriteEn=1, `instr_done`. Next FETCH.
- EXEC_I (8): ALUSrcA=01, ALUSrcB=10, ALUOp = add (addi), or (ori) or xor (xori). Next WB_I.
- WB_I (9): RegDst=00, MemtoReg=00, RegWriteEn=1, `instr_done`. Next FETCH.
- BRANCH (10): ALUSrcA=01, ALUSrcB=00, ALUOp=sub, PCSource=01.
  - PCWrite = `zero` for beq, `~zero` for bne.
  - Assert `instr_done`. Next FETCH.
- JAL (11): PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10, RegWriteEn=1, `instr_done`. Next FETCH.
  - The register file receives PC, which already holds PC+4.
- JR (12): ALUSrcA=01, PCWrite=1, PCSource=11, `instr_done`. Next FETCH.
- Unused state encodings go to FETCH on the next edge.

## Timing
- Reset: while `rst`=0 at a clock edge, state←FETCH. During any cycle with `rst`=0, every output is forced to 0 and `state` reads 0.
- Reset mid-instruction abandons the instruction; no partial write-back occurs after the reset cycle.
- CPI with zero memory wait:
  - beq/bne/jal/jr: 3.
  - R-type, I-type ALU, sw: 4.
  - lw: 5.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold steady while waiting.
- `instr_done` is exactly one pulse per instruction, including illegal ones.

## Structure
- Shared package `cpu_defs_pkg` holds:
  - opcode and funct constants;
  - ALUOp encodings;
  - the RegDst/MemtoReg/ALUSrcA/ALUSrcB/PCSource select encodings;
  - the state enum.
- The single-cycle decoder imports the same package.
- Sub-module `alu_funct_decoder`: combinational funct→{ALUOp, is_shift, is_jr, valid}, used in DECODE and EXEC_R.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `mem_ready`=1 → all outputs 0 and `state`=0. After release, FETCH shows MemReadEn=1 and IRWrite=1.
- **add then lw, `mem_ready` always 1:** add gives 4 cycles, with RegWriteEn=1, RegDst=01 and ALUOp=0000 in cycle 4. lw gives 5 cycles, with MemtoReg=01 in cycle 5.
- **sw with memory wait:** `mem_ready`=0 for 2 cycles in MEMWR → MemWriteEn=1 held for 3 cycles, then exactly one `instr_done`. Total is 6 cycles.
- **Branches:**
  - beq with `zero`=1 → PCWrite=1 and PCSource=01.
  - beq with `zero`=0 → PCWrite=0.
  - bne with `zero`=0 → PCWrite=1.
- **jal and jr:**
  - jal → RegDst=10, MemtoReg=10, PCSource=10 in cycle 3.
  - jr → PCSource=11, RegWriteEn=0.
- **Illegal decode:** opCode=3F, or R-type with funct=3F → `illegal` and `instr_done` pulse in DECODE, then FETCH, with no RegWriteEn or MemWriteEn asserted. Separately, sll → ALUSrcA=10 and ALUOp=1000.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared SDC24 QP core definitions: opcodes, functs,
// ALU operations, datapath select encodings and controller states.
package cpu_defs_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h16;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SGT = 6'h14;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_XOR = 6'h15;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SGT = 4'd5,
    ALU_NOR = 4'd6,
    ALU_XOR = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9
  } aluop_t;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_A     = 2'b01;
  localparam logic [1:0] SA_SHAMT = 2'b10;

  localparam logic [1:0] SB_B    = 2'b00;
  localparam logic [1:0] SB_4    = 2'b01;
  localparam logic [1:0] SB_IMM  = 2'b10;
  localparam logic [1:0] SB_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_A      = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_WB_MEM  = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_WB_R    = 4'd7,
    S_EXEC_I  = 4'd8,
    S_WB_I    = 4'd9,
    S_BRANCH  = 4'd10,
    S_JAL     = 4'd11,
    S_JR      = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller (slave)
// and the datapath side that feeds it IR fields and flags (master).
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opCode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               IorD;
  logic               MemReadEn;
  logic               MemWriteEn;
  logic               IRWrite;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               RegWriteEn;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [3:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               instr_done;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    output opCode, funct, zero, mem_ready,
    input  PCWrite, IorD, MemReadEn, MemWriteEn,
    input  IRWrite, RegDst, MemtoReg, RegWriteEn,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource,
    input  instr_done, illegal, state
  );

  modport slave (
    input  opCode, funct, zero, mem_ready,
    output PCWrite, IorD, MemReadEn, MemWriteEn,
    output IRWrite, RegDst, MemtoReg, RegWriteEn,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource,
    output instr_done, illegal, state
  );
endinterface

// File: rtl/alu_funct_decoder.sv
// R-type funct decode: ALU operation, shift/jr flags and
// whether the funct is supported at all.
module alu_funct_decoder
  import cpu_defs_pkg::*;
(
  input  logic [5:0] funct,
  output aluop_t     alu_op,
  output logic       is_shift,
  output logic       is_jr,
  output logic       valid
);

  always_comb begin
    alu_op   = ALU_ADD;
    is_shift = 1'b0;
    is_jr    = 1'b0;
    valid    = 1'b1;
    unique case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_SLT: alu_op = ALU_SLT;
      FN_SGT: alu_op = ALU_SGT;
      FN_NOR: alu_op = ALU_NOR;
      FN_XOR: alu_op = ALU_XOR;
      FN_SLL: begin
        alu_op   = ALU_SLL;
        is_shift = 1'b1;
      end
      FN_SRL: begin
        alu_op   = ALU_SRL;
        is_shift = 1'b1;
      end
      FN_JR:  is_jr = 1'b1;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle QP core; only the
// mem_ready and zero inputs gate outputs within a cycle.
module multicycle_controller
  import cpu_defs_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input logic clk,
  input logic rst,
  multicycle_controller_if.slave bus
);

  state_t state_q, state_d;

  aluop_t fn_op;
  logic   fn_shift, fn_jr, fn_valid;

  alu_funct_decoder u_fdec (
    .funct    (bus.funct),
    .alu_op   (fn_op),
    .is_shift (fn_shift),
    .is_jr    (fn_jr),
    .valid    (fn_valid)
  );

  logic [5:0] op;
  logic is_r, is_mem, is_i, is_br, is_jal;

  assign op     = bus.opCode;
  assign is_r   = op == OP_R;
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_i   = (op == OP_ADDI) || (op == OP_ORI)
               || (op == OP_XORI);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_jal = op == OP_JAL;

  logic       pc_wr, iord, mem_rd, mem_wr, ir_wr;
  logic       reg_wr, done, ill;
  logic [1:0] reg_dst, mem_to_reg, alu_a, alu_b, pc_src;
  aluop_t     alu_op;

  always_comb begin
    state_d    = state_q;
    pc_wr      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    done       = 1'b0;
    ill        = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = WB_ALU;
    alu_a      = SA_PC;
    alu_b      = SB_B;
    pc_src     = PC_ALU;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        alu_b  = SB_4;
        if (bus.mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_b = SB_IMM2;
        unique case (1'b1)
          is_mem: state_d = S_MEMADDR;
          is_r && fn_valid && !fn_jr:
            state_d = S_EXEC_R;
          is_r && fn_jr: state_d = S_JR;
          is_i:   state_d = S_EXEC_I;
          is_br:  state_d = S_BRANCH;
          is_jal: state_d = S_JAL;
          default: begin
            ill     = 1'b1;
            done    = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        alu_a   = SA_A;
        alu_b   = SB_IMM;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_to_reg = WB_MDR;
        reg_wr     = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_a   = fn_shift ? SA_SHAMT : SA_A;
        alu_op  = fn_op;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_dst = RD_RD;
        reg_wr  = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        alu_a   = SA_A;
        alu_b   = SB_IMM;
        alu_op  = (op == OP_ORI)  ? ALU_OR
                : (op == OP_XORI) ? ALU_XOR
                : ALU_ADD;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        reg_wr  = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_a   = SA_A;
        alu_op  = ALU_SUB;
        pc_src  = PC_ALUOUT;
        pc_wr   = (op == OP_BNE) ? ~bus.zero : bus.zero;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so it is the link value
        pc_wr      = 1'b1;
        pc_src     = PC_JUMP;
        reg_dst    = RD_RA;
        mem_to_reg = WB_PC;
        reg_wr     = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        alu_a   = SA_A;
        pc_wr   = 1'b1;
        pc_src  = PC_A;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Reset masks every output in the same cycle, so an
  // abandoned instruction cannot write anything back.
  assign bus.PCWrite    = rst & pc_wr;
  assign bus.IorD       = rst & iord;
  assign bus.MemReadEn  = rst & mem_rd;
  assign bus.MemWriteEn = rst & mem_wr;
  assign bus.IRWrite    = rst & ir_wr;
  assign bus.RegWriteEn = rst & reg_wr;
  assign bus.instr_done = rst & done;
  assign bus.illegal    = rst & ill;
  assign bus.RegDst     = rst ? reg_dst    : '0;
  assign bus.MemtoReg   = rst ? mem_to_reg : '0;
  assign bus.ALUSrcA    = rst ? alu_a      : '0;
  assign bus.ALUSrcB    = rst ? alu_b      : '0;
  assign bus.ALUOp      = rst ? alu_op     : '0;
  assign bus.PCSource   = rst ? pc_src     : '0;
  assign bus.state      = rst ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle checks of the full control vector
// and debug state of multicycle_controller.
module tb_multicycle_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_controller_if #(.STATE_W(4)) bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [25:0] obs;
  assign obs = {bus.PCWrite, bus.IorD, bus.MemReadEn,
                bus.MemWriteEn, bus.IRWrite, bus.RegDst,
                bus.MemtoReg, bus.RegWriteEn, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                bus.instr_done, bus.illegal, bus.state};

  function automatic logic [25:0] ev(
    int pcw, int iord, int mrd, int mwr, int irw,
    int rdst, int m2r, int rw, int sa, int sb,
    int op, int pcs, int dn, int ill, int st);
    return {pcw[0], iord[0], mrd[0], mwr[0], irw[0],
            rdst[1:0], m2r[1:0], rw[0], sa[1:0], sb[1:0],
            op[3:0], pcs[1:0], dn[0], ill[0], st[3:0]};
  endfunction

  localparam logic [25:0] E_ZERO  =
    ev(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
  localparam logic [25:0] E_FETCH =
    ev(1,0,1,0,1, 0,0,0,0,1, 0,0,0,0,0);
  localparam logic [25:0] E_FWAIT =
    ev(0,0,1,0,0, 0,0,0,0,1, 0,0,0,0,0);
  localparam logic [25:0] E_DEC   =
    ev(0,0,0,0,0, 0,0,0,0,3, 0,0,0,0,1);
  localparam logic [25:0] E_DECI  =
    ev(0,0,0,0,0, 0,0,0,0,3, 0,0,1,1,1);
  localparam logic [25:0] E_MADDR =
    ev(0,0,0,0,0, 0,0,0,1,2, 0,0,0,0,2);
  localparam logic [25:0] E_MRD   =
    ev(0,1,1,0,0, 0,0,0,0,0, 0,0,0,0,3);
  localparam logic [25:0] E_WBM   =
    ev(0,0,0,0,0, 0,1,1,0,0, 0,0,1,0,4);
  localparam logic [25:0] E_MWRW  =
    ev(0,1,0,1,0, 0,0,0,0,0, 0,0,0,0,5);
  localparam logic [25:0] E_MWRD  =
    ev(0,1,0,1,0, 0,0,0,0,0, 0,0,1,0,5);
  localparam logic [25:0] E_WBR   =
    ev(0,0,0,0,0, 1,0,1,0,0, 0,0,1,0,7);
  localparam logic [25:0] E_WBI   =
    ev(0,0,0,0,0, 0,0,1,0,0, 0,0,1,0,9);
  localparam logic [25:0] E_JAL   =
    ev(1,0,0,0,0, 2,2,1,0,0, 0,2,1,0,11);
  localparam logic [25:0] E_JR    =
    ev(1,0,0,0,0, 0,0,0,1,0, 0,3,1,0,12);

  task automatic cyc(input string tag, input bit rdy,
                     input bit z, input logic [25:0] e);
    bus.mem_ready = rdy;
    bus.zero      = z;
    #1;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, e);
    end
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    bus.opCode    = 6'h00;
    bus.funct     = 6'h20;
    @(negedge clk);

    cyc("rst_c1", 1, 0, E_ZERO);
    cyc("rst_c2", 1, 0, E_ZERO);
    cyc("rst_c3", 1, 0, E_ZERO);
    rst = 1'b1;

    cyc("add_fetch", 1, 0, E_FETCH);
    cyc("add_dec",   1, 0, E_DEC);
    cyc("add_exec",  1, 0,
        ev(0,0,0,0,0, 0,0,0,1,0, 0,0,0,0,6));
    cyc("add_wb",    1, 0, E_WBR);

    bus.opCode = 6'h23;
    cyc("lw_fetch", 1, 0, E_FETCH);
    cyc("lw_dec",   1, 0, E_DEC);
    cyc("lw_addr",  1, 0, E_MADDR);
    cyc("lw_rd",    1, 0, E_MRD);
    cyc("lw_wb",    1, 0, E_WBM);

    bus.opCode = 6'h2B;
    cyc("sw_fetch", 1, 0, E_FETCH);
    cyc("sw_dec",   1, 0, E_DEC);
    cyc("sw_addr",  1, 0, E_MADDR);
    cyc("sw_wait1", 0, 0, E_MWRW);
    cyc("sw_wait2", 0, 0, E_MWRW);
    cyc("sw_done",  1, 0, E_MWRD);

    bus.opCode = 6'h08;
    cyc("addi_fwait", 0, 0, E_FWAIT);
    cyc("addi_fetch", 1, 0, E_FETCH);
    cyc("addi_dec",   1, 0, E_DEC);
    cyc("addi_exec",  1, 0,
        ev(0,0,0,0,0, 0,0,0,1,2, 0,0,0,0,8));
    cyc("addi_wb",    1, 0, E_WBI);

    bus.opCode = 6'h0D;
    cyc("ori_fetch", 1, 0, E_FETCH);
    cyc("ori_dec",   1, 0, E_DEC);
    cyc("ori_exec",  1, 0,
        ev(0,0,0,0,0, 0,0,0,1,2, 3,0,0,0,8));
    cyc("ori_wb",    1, 0, E_WBI);

    bus.opCode = 6'h16;
    cyc("xori_fetch", 1, 0, E_FETCH);
    cyc("xori_dec",   1, 0, E_DEC);
    cyc("xori_exec",  1, 0,
        ev(0,0,0,0,0, 0,0,0,1,2, 7,0,0,0,8));
    cyc("xori_wb",    1, 0, E_WBI);

    bus.opCode = 6'h04;
    cyc("beq1_fetch", 1, 0, E_FETCH);
    cyc("beq1_dec",   1, 0, E_DEC);
    cyc("beq1_br",    1, 1,
        ev(1,0,0,0,0, 0,0,0,1,0, 1,1,1,0,10));
    cyc("beq0_fetch", 1, 0, E_FETCH);
    cyc("beq0_dec",   1, 0, E_DEC);
    cyc("beq0_br",    1, 0,
        ev(0,0,0,0,0, 0,0,0,1,0, 1,1,1,0,10));

    bus.opCode = 6'h05;
    cyc("bne0_fetch", 1, 0, E_FETCH);
    cyc("bne0_dec",   1, 0, E_DEC);
    cyc("bne0_br",    1, 0,
        ev(1,0,0,0,0, 0,0,0,1,0, 1,1,1,0,10));
    cyc("bne1_fetch", 1, 0, E_FETCH);
    cyc("bne1_dec",   1, 0, E_DEC);
    cyc("bne1_br",    1, 1,
        ev(0,0,0,0,0, 0,0,0,1,0, 1,1,1,0,10));

    bus.opCode = 6'h03;
    cyc("jal_fetch", 1, 0, E_FETCH);
    cyc("jal_dec",   1, 0, E_DEC);
    cyc("jal_exec",  1, 0, E_JAL);

    bus.opCode = 6'h00;
    bus.funct  = 6'h08;
    cyc("jr_fetch", 1, 0, E_FETCH);
    cyc("jr_dec",   1, 0, E_DEC);
    cyc("jr_exec",  1, 0, E_JR);

    bus.opCode = 6'h3F;
    bus.funct  = 6'h20;
    cyc("ill_op_fetch", 1, 0, E_FETCH);
    cyc("ill_op_dec",   1, 0, E_DECI);

    bus.opCode = 6'h00;
    bus.funct  = 6'h3F;
    cyc("ill_fn_fetch", 1, 0, E_FETCH);
    cyc("ill_fn_dec",   1, 0, E_DECI);

    bus.funct = 6'h00;
    cyc("sll_fetch", 1, 0, E_FETCH);
    cyc("sll_dec",   1, 0, E_DEC);
    cyc("sll_exec",  1, 0,
        ev(0,0,0,0,0, 0,0,0,2,0, 8,0,0,0,6));
    cyc("sll_wb",    1, 0, E_WBR);

    bus.funct = 6'h14;
    cyc("sgt_fetch", 1, 0, E_FETCH);
    cyc("sgt_dec",   1, 0, E_DEC);
    cyc("sgt_exec",  1, 0,
        ev(0,0,0,0,0, 0,0,0,1,0, 5,0,0,0,6));
    cyc("sgt_wb",    1, 0, E_WBR);

    bus.opCode = 6'h23;
    cyc("lww_fetch", 1, 0, E_FETCH);
    cyc("lww_dec",   1, 0, E_DEC);
    cyc("lww_addr",  1, 0, E_MADDR);
    cyc("lww_wait",  0, 0, E_MRD);
    cyc("lww_rd",    1, 0, E_MRD);
    cyc("lww_wb",    1, 0, E_WBM);

    cyc("lwr_fetch", 1, 0, E_FETCH);
    cyc("lwr_dec",   1, 0, E_DEC);
    rst = 1'b0;
    cyc("lwr_rst",   1, 0, E_ZERO);
    rst = 1'b1;
    cyc("lwr_refetch", 1, 0, E_FETCH);
    cyc("lwr_redec",   1, 0, E_DEC);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
